ms_timer_arbiter: RTL and testbench
===================================

# ms_timer_arbiter

Shared millisecond delay timer with round-robin arbitration among four requesters. Each requester (motor sequencer, turn controller, sensor poller, UI debounce) asks for a delay of N milliseconds. The block grants one requester at a time, runs a single prescaler-plus-countdown from the system clock, and pulses that requester's done line when the delay expires. Timing is carried by a synchronous single-cycle tick enable; no derived clocks are created.

## Interface
- TICK_DIV, 100000, system-clock cycles per 1 ms tick (100 MHz clk); minimum 2
- DLY_W, 16, width of each delay request in ms
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  reset; asynchronous, active-low; clock clk
- req  in  4  level request per requester; held high until done[i] or withdrawn (cancel)
- dly_ms  in  4*DLY_W  delay for requester i at bits [i*DLY_W +: DLY_W]; sampled only at grant
- grant  out  4  one-hot owner of the timer; all zero when idle
- done  out  4  one-cycle pulse on the owner's bit when its delay expires
- busy  out  1  high whenever state is not IDLE
- tick_ms  out  1  one-cycle pulse each time the prescaler wraps

## Operation
- Prescaler: counter 0..TICK_DIV-1 (32-bit); tick_ms = (prescaler == TICK_DIV-1); wraps to 0 after the tick. Free-running in IDLE. Forced to 0 on the grant edge so the first tick comes exactly TICK_DIV cycles after grant.
- Countdown: DLY_W-bit register loaded with the owner's dly_ms at grant. Decrements on each tick in COUNT and never underflows.
- Round-robin pointer `last` (2 bits), reset to 3, so requester 0 has top priority first. Search order is last+1, last+2, last+3, last (mod 4). `last` updates to the winner at each grant.
- FSM states: IDLE, COUNT, DONE.
- IDLE, req==0: stay.
- IDLE, req!=0: latch the winner and set its grant bit. If the sampled delay is 0, go to DONE; otherwise load the countdown, clear the prescaler and go to COUNT.
- COUNT, req[owner] low: withdrawal. Go to IDLE, clear grant, no done.
- COUNT, tick with countdown==1: go to DONE.
- COUNT, tick with countdown>1: decrement and stay.
- Withdrawal has priority over a same-cycle final tick.
- DONE: done[owner]=1 and grant still held for this one cycle. Go to IDLE unconditionally; req is ignored in this state.
- A requester that holds req high after done re-enters arbitration as a new request. Because `last` points at it, every other pending requester is served first.
- Changes on dly_ms or on non-owner req bits during COUNT/DONE have no effect on the running delay.
- Reset values: grant=0, done=0, busy=0, tick_ms=0, state=IDLE, prescaler=0, countdown=0, last=3.
- Reset asserted mid-operation clears everything asynchronously. No done is emitted and the delay is lost.

## Timing
- req rising in IDLE -> grant registered at the next posedge (1-cycle latency).
- Grant edge E0, dly=D>0:
  - tick_ms pulses in the cycles preceding edges E0+k*TICK_DIV, k=1..D.
  - State enters DONE at edge E0+D*TICK_DIV.
  - done high for exactly one cycle; grant high for D*TICK_DIV+1 cycles total.
- dly=0: grant and done high together for exactly one cycle, starting 1 cycle after the request is seen.
- Back-to-back: after DONE there is one IDLE cycle, then the next grant. Gap between one done and the next grant is 1 cycle.
- Withdrawal: grant drops at the edge after req[owner] is sampled low. The next arbitration happens in the following IDLE cycle.
- busy = state != IDLE, so it tracks grant!=0 exactly.

## Test plan
- Reset, TICK_DIV=4, req=0 -> all outputs 0; tick_ms pulses every 4 cycles starting in the 4th cycle after reset release.
- TICK_DIV=4, req=4'b0001, dly0=3 -> grant=0001 one cycle later; done[0] pulses 12 cycles after the grant edge; grant held 13 cycles; busy matches grant.
- req=4'b1111 held from reset, dly=1 for all -> grants in order 0,1,2,3,0,...; each done is followed by the next grant 1 cycle later; never two grant bits high.
- req=4'b0100 with dly2=0 -> grant=0100 and done=0100 in the same single cycle; then IDLE.
- req={1,0,1,0} (bits 3 and 1), dly=5; drop req[1] 6 cycles into its COUNT -> grant[1] clears next edge, no done[1]; grant[3] follows after one IDLE cycle.
- Assert rst_n low mid-COUNT -> grant/done/busy go to 0 immediately without waiting for a clock edge; after release, a fresh request is timed from zero.

Source files
------------

// File: rtl/ms_timer_arbiter.sv
// ms_timer_arbiter: one millisecond delay timer shared round-robin among four requesters
module ms_timer_arbiter #(
    parameter int TICK_DIV = 100000,
    parameter int DLY_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*DLY_W-1:0] dly_ms,
    output logic [3:0]         grant,
    output logic [3:0]         done,
    output logic               busy,
    output logic               tick_ms
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t             state;
    logic [31:0]        presc;
    logic [DLY_W-1:0]   cnt;
    logic [DLY_W-1:0]   win_dly;
    logic [1:0]         last;
    logic [1:0]         owner;
    logic [1:0]         win;
    logic [1:0]         idx;
    logic               go;
    assign tick_ms = presc == 32'(TICK_DIV - 1);
    assign busy    = state != IDLE;
    assign go      = state == IDLE && |req;
    assign win_dly = dly_ms[win*DLY_W +: DLY_W];
    // scanning from lowest to highest priority lets the nearest requester after last win
    always_comb begin
        win = last;
        idx = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            win = req[idx] ? idx : win;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            presc <= '0;
            cnt   <= '0;
            last  <= 2'd3;
            owner <= '0;
            grant <= '0;
            done  <= '0;
        end else begin
            presc <= ((go && win_dly != 0) || tick_ms) ? '0 : presc + 1;
            case (state)
                IDLE: if (|req) begin
                    owner <= win;
                    last  <= win;
                    grant <= 4'b1 << win;
                    if (win_dly == 0) begin
                        state <= DONE;
                        done  <= 4'b1 << win;
                    end else begin
                        cnt   <= win_dly;
                        state <= COUNT;
                    end
                end
                COUNT: if (!req[owner]) begin
                    state <= IDLE;
                    grant <= '0;
                end else if (tick_ms) begin
                    cnt <= (cnt != 0) ? cnt - 1 : cnt;
                    if (cnt == 1) begin
                        state <= DONE;
                        done  <= grant;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    done  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ms_timer_arbiter.sv
// tb_ms_timer_arbiter: directed stimulus checked every cycle against a cycle-count model
module tb_ms_timer_arbiter;
    localparam int T = 4;
    localparam int W = 16;
    logic         clk = 0;
    logic         rst_n;
    logic [3:0]   req = '0;
    logic [4*W-1:0] dly_ms = '0;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;
    logic         tick_ms;
    int tests = 0;
    int fails = 0;

    ms_timer_arbiter #(.TICK_DIV(T), .DLY_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dly_ms(dly_ms),
        .grant(grant), .done(done), .busy(busy), .tick_ms(tick_ms)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int lst);
        for (int k = 1; k <= 4; k++)
            if (r[(lst + k) % 4]) return (lst + k) % 4;
        return lst;
    endfunction

    // model: timing by absolute edge numbers, expiry = grant edge + D*T
    int ec = 0, base = 0, m_end = 0, m_own = 0, m_last = 3, d;
    bit m_busy = 0, m_done = 0;
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ec = 0; base = 0; m_busy = 0; m_done = 0; m_own = 0; m_last = 3;
        end else begin
            ec++;
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (req != 0) begin
                    m_own  = pick(req, m_last);
                    m_last = m_own;
                    m_busy = 1;
                    d = int'(dly_ms[m_own*W +: W]);
                    if (d == 0) m_done = 1;
                    else begin
                        m_end = ec + d * T;
                        base  = ec;
                    end
                end
            end else if (!req[m_own]) m_busy = 0;
            else if (ec == m_end) m_done = 1;
        end
    end

    always @(negedge clk) begin
        check("grant", grant, m_busy ? 32'(4'b1 << m_own) : 0);
        check("done", done, m_done ? 32'(4'b1 << m_own) : 0);
        check("busy", busy, m_busy);
        check("tick", tick_ms, ((ec - base) % T) == T - 1);
        check("onehot", $countones(grant) <= 1, 1);
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    int n, dn, g, seen;
    int order [5];
    logic [3:0] prev;
    initial begin
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_tick", tick_ms, 0);
        #1 rst_n = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("idle_tick", tick_ms, (i % 4) == 0);
        end
        // single request, 3 ms
        @(posedge clk); #2;
        dly_ms[0 +: W] = 3;
        req = 4'b0001;
        @(posedge clk);
        n = 0; dn = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!grant[0]) break;
            n++;
            if (done[0]) begin dn = n; req = 0; end
        end
        check("t2_grant_len", n, 13);
        check("t2_done_at", dn, 13);
        // all four requesting, 1 ms each, from reset
        @(posedge clk); #2;
        rst_n = 0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) dly_ms[i*W +: W] = 1;
        #10 rst_n = 1;
        g = 0; prev = 0; n = 0;
        while (g < 5 && n < 200) begin
            @(negedge clk);
            n++;
            if (grant != 0 && prev == 0) begin
                for (int i = 0; i < 4; i++) if (grant[i]) order[g] = i;
                g++;
            end
            prev = grant;
        end
        req = 0;
        check("t3_grants", g, 5);
        for (int i = 0; i < 5; i++) check("t3_order", order[i], i % 4);
        repeat (10) @(negedge clk);
        // zero-length delay
        @(posedge clk); #2;
        dly_ms[2*W +: W] = 0;
        req = 4'b0100;
        @(negedge clk);
        check("t4_latency", grant, 0);
        @(negedge clk);
        check("t4_grant", grant, 4'b0100);
        check("t4_done", done, 4'b0100);
        req = 0;
        @(negedge clk);
        check("t4_idle_grant", grant, 0);
        check("t4_idle_done", done, 0);
        // withdrawal of requester 1, then requester 3 served
        @(posedge clk); #2;
        rst_n = 0;
        dly_ms[1*W +: W] = 5;
        dly_ms[3*W +: W] = 5;
        req = 4'b1010;
        #10 rst_n = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = grant != 0;
        end
        check("t5_first", grant, 4'b0010);
        repeat (6) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        check("t5_drop_grant", grant, 0);
        check("t5_drop_done", done, 0);
        @(negedge clk);
        check("t5_next", grant, 4'b1000);
        // asynchronous reset mid-count, then a fresh 2 ms request
        repeat (5) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("t6_async_grant", grant, 0);
        check("t6_async_done", done, 0);
        check("t6_async_busy", busy, 0);
        dly_ms[0 +: W] = 2;
        req = 4'b0001;
        @(posedge clk); #2;
        rst_n = 1;
        @(posedge clk);
        n = 0; dn = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!grant[0]) break;
            n++;
            if (done[0]) begin dn = n; req = 0; end
        end
        check("t6_grant_len", n, 9);
        check("t6_done_at", dn, 9);
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
